// File: rtl/ysyx_23060240_axi_pkg.sv
// ysyx_23060240_axi_pkg
// Shared definitions for the IFU/LSU AXI arbiter:
//   state_t     - arbiter FSM states (one transaction outstanding at a time)
//   ID_W        - AXI ID width used on every port
//   ID_IFU/LSU  - fixed transaction IDs tagged onto the memory-side port
//   LEN_SINGLE  - single-beat burst length
//   SIZE_WORD   - 4-byte beat size
//   BURST_INCR  - INCR burst type
//   RESP_*      - AXI response encodings
package ysyx_23060240_axi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    localparam int              ID_W        = 4;
    localparam logic [ID_W-1:0] ID_IFU      = ID_W'(0);
    localparam logic [ID_W-1:0] ID_LSU      = ID_W'(1);
    localparam logic [7:0]      LEN_SINGLE  = 8'd0;
    localparam logic [2:0]      SIZE_WORD   = 3'b010;
    localparam logic [1:0]      BURST_INCR  = 2'b01;
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_23060240_axi_arbiter_if.sv
// ysyx_23060240_axi_arbiter_if
// Single-ID AXI4 bus bundle (ar, r, aw, w, b channels) used for the IFU,
// LSU and memory-side ports of the arbiter.
//   modport master : drives addresses/data/valids, receives readys/responses
//   modport slave  : the mirror image
// Parameters: ADDR_W address width, DATA_W data width.
interface ysyx_23060240_axi_arbiter_if
    import ysyx_23060240_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // read address
    logic [ADDR_W-1:0]   araddr;
    logic [ID_W-1:0]     arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    // read data
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic [ID_W-1:0]     rid;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    // write address
    logic [ADDR_W-1:0]   awaddr;
    logic [ID_W-1:0]     awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    // write data
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    // write response
    logic [1:0]          bresp;
    logic [ID_W-1:0]     bid;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );

endinterface

// File: rtl/ysyx_23060240_arb_pick.sv
// ysyx_23060240_arb_pick
// Grant selector: from the live requests (and, when round robin is built in,
// the last-granted master) chooses the state the arbiter enters next.
// Ports:
//   ifu_ar     in  IFU read-address request
//   lsu_ar     in  LSU read-address request
//   lsu_aw     in  LSU write-address request
//   last_lsu   in  last grant went to the LSU (only with ARB_RR_EN)
//   next_state out state to enter on leaving IDLE (IDLE if nothing requested)
// Build option: ARB_RR_EN - alternate between IFU and LSU under contention;
// otherwise fixed priority lsu_aw > lsu_ar > ifu_ar.
module ysyx_23060240_arb_pick
    import ysyx_23060240_axi_pkg::*;
(
    input  logic   ifu_ar,
    input  logic   lsu_ar,
    input  logic   lsu_aw,
`ifdef ARB_RR_EN
    input  logic   last_lsu,
`endif
    output state_t next_state
);

    logic   lsu_req;
    state_t lsu_state;

    always_comb begin
        lsu_req    = lsu_ar | lsu_aw;
        // inside the LSU a pending write always beats a pending read
        lsu_state  = lsu_aw ? LSU_WR : LSU_RD;
        next_state = IDLE;
`ifdef ARB_RR_EN
        if (lsu_req && ifu_ar) begin
            next_state = last_lsu ? IFU_RD : lsu_state;
        end else if (lsu_req) begin
            next_state = lsu_state;
        end else if (ifu_ar) begin
            next_state = IFU_RD;
        end
`else
        if (lsu_req) begin
            next_state = lsu_state;
        end else if (ifu_ar) begin
            next_state = IFU_RD;
        end
`endif
    end

endmodule

// File: rtl/ysyx_23060240_axi_arbiter.sv
// ysyx_23060240_axi_arbiter
// Shares one single-ID AXI4 memory port between the IFU (read only) and the
// LSU (read and write). Exactly one transaction is in flight; a grant is
// decided in IDLE and registered, so every grant costs one cycle.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   ifu       slave modport  - IFU ar/r channels (aw/w/b tied off)
//   lsu       slave modport  - LSU ar/r/aw/w/b channels
//   m         master modport - toward the memory slave
// Parameters: ADDR_W, DATA_W (must match the connected interfaces).
// Build option: ARB_RR_EN - round-robin IFU/LSU arbitration with a last-grant
// register; without it, fixed priority lsu aw > lsu ar > ifu ar.
module ysyx_23060240_axi_arbiter
    import ysyx_23060240_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060240_axi_arbiter_if.slave    ifu,
    ysyx_23060240_axi_arbiter_if.slave    lsu,
    ysyx_23060240_axi_arbiter_if.master   m
);

    state_t state_reg;
    state_t pick_state;
    // Address/data beats already accepted in the current transaction; they
    // stop a master that re-asserts valid early from issuing a second access.
    logic   ar_done_reg;
    logic   aw_done_reg;
    logic   w_done_reg;
`ifdef ARB_RR_EN
    logic   last_lsu_reg;
`endif

    logic              rd_ifu, rd_lsu, wr_lsu;
    logic              ar_valid, aw_valid, w_valid, r_ready, b_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [DATA_W-1:0] r_data;

    ysyx_23060240_arb_pick u_pick (
        .ifu_ar     (ifu.arvalid),
        .lsu_ar     (lsu.arvalid),
        .lsu_aw     (lsu.awvalid),
`ifdef ARB_RR_EN
        .last_lsu   (last_lsu_reg),
`endif
        .next_state (pick_state)
    );

    always_comb begin
        rd_ifu   = (state_reg == IFU_RD);
        rd_lsu   = (state_reg == LSU_RD);
        wr_lsu   = (state_reg == LSU_WR);
        ar_valid = ~ar_done_reg & ((rd_ifu & ifu.arvalid) | (rd_lsu & lsu.arvalid));
        ar_addr  = rd_ifu ? ifu.araddr : lsu.araddr;
        r_ready  = (rd_ifu & ifu.rready) | (rd_lsu & lsu.rready);
        aw_valid = wr_lsu & ~aw_done_reg & lsu.awvalid;
        w_valid  = wr_lsu & ~w_done_reg & lsu.wvalid;
        b_ready  = wr_lsu & lsu.bready;
        r_data   = m.rdata;
    end

    // memory-side port
    assign m.araddr  = ar_addr;
    assign m.arid    = rd_ifu ? ID_IFU : ID_LSU;
    assign m.arlen   = LEN_SINGLE;
    assign m.arsize  = SIZE_WORD;
    assign m.arburst = BURST_INCR;
    assign m.arvalid = ar_valid;
    assign m.rready  = r_ready;
    assign m.awaddr  = lsu.awaddr;
    assign m.awid    = ID_LSU;
    assign m.awlen   = LEN_SINGLE;
    assign m.awsize  = SIZE_WORD;
    assign m.awburst = BURST_INCR;
    assign m.awvalid = aw_valid;
    assign m.wdata   = lsu.wdata;
    assign m.wstrb   = lsu.wstrb;
    assign m.wlast   = 1'b1;
    assign m.wvalid  = w_valid;
    assign m.bready  = b_ready;

    // IFU side: read only, write channels permanently idle
    assign ifu.arready = rd_ifu & ~ar_done_reg & m.arready;
    assign ifu.rdata   = r_data;
    assign ifu.rresp   = m.rresp;
    assign ifu.rid     = m.rid;
    assign ifu.rlast   = m.rlast;
    assign ifu.rvalid  = rd_ifu & m.rvalid;
    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bresp   = RESP_OKAY;
    assign ifu.bid     = ID_IFU;
    assign ifu.bvalid  = 1'b0;

    // LSU side
    assign lsu.arready = rd_lsu & ~ar_done_reg & m.arready;
    assign lsu.rdata   = r_data;
    assign lsu.rresp   = m.rresp;
    assign lsu.rid     = m.rid;
    assign lsu.rlast   = m.rlast;
    assign lsu.rvalid  = rd_lsu & m.rvalid;
    assign lsu.awready = wr_lsu & ~aw_done_reg & m.awready;
    assign lsu.wready  = wr_lsu & ~w_done_reg & m.wready;
    assign lsu.bresp   = m.bresp;
    assign lsu.bid     = m.bid;
    assign lsu.bvalid  = wr_lsu & m.bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ar_done_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
`ifdef ARB_RR_EN
            last_lsu_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg   <= pick_state;
                    ar_done_reg <= 1'b0;
                    aw_done_reg <= 1'b0;
                    w_done_reg  <= 1'b0;
`ifdef ARB_RR_EN
                    if (pick_state != IDLE) begin
                        last_lsu_reg <= (pick_state != IFU_RD);
                    end
`endif
                end
                IFU_RD, LSU_RD: begin
                    if (ar_valid && m.arready) begin
                        ar_done_reg <= 1'b1;
                    end
                    // error responses end the transaction just like OKAY
                    if (m.rvalid && r_ready) begin
                        state_reg <= IDLE;
                    end
                end
                LSU_WR: begin
                    if (aw_valid && m.awready) begin
                        aw_done_reg <= 1'b1;
                    end
                    if (w_valid && m.wready) begin
                        w_done_reg <= 1'b1;
                    end
                    if (m.bvalid && b_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_axi_arbiter.sv
// tb_ysyx_23060240_axi_arbiter
// Directed bench: stimulus tasks push expected beats into queues, a negedge
// monitor pops and compares whenever a handshake appears on any port.
// Optional build: ARB_RR_EN selects the round-robin grant order expectations.
module tb_ysyx_23060240_axi_arbiter;
    import ysyx_23060240_axi_pkg::*;

    localparam int TMO = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_23060240_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_bus ();
    ysyx_23060240_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
    ysyx_23060240_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

    ysyx_23060240_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_bus),
        .lsu (lsu_bus),
        .m   (m_bus)
    );

    typedef struct { logic [31:0] addr; logic [3:0] id; } a_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;

    a_exp_t     m_ar_q[$];
    a_exp_t     m_aw_q[$];
    w_exp_t     m_w_q[$];
    r_exp_t     ifu_r_q[$];
    r_exp_t     lsu_r_q[$];
    logic [1:0] lsu_b_q[$];

    int vectors = 0;
    int miscompares = 0;

    logic hs_ifu_ar, hs_ifu_r, hs_lsu_ar, hs_lsu_r, hs_lsu_aw, hs_lsu_w, hs_lsu_b;
    logic hs_m_ar, hs_m_r, hs_m_aw, hs_m_w, hs_m_b;
    logic [31:0] cap_ar_addr;
    logic [3:0]  cap_ar_id, cap_aw_id;

    int         slave_lat   = 1;
    logic [1:0] slave_rresp = RESP_OKAY;
    logic [1:0] slave_bresp = RESP_OKAY;
    logic       slave_abort = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: got unexpected/missing event, want expected handshake", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        a_exp_t ea;
        r_exp_t er;
        w_exp_t ew;
        hs_ifu_ar = ifu_bus.arvalid && ifu_bus.arready;
        hs_ifu_r  = ifu_bus.rvalid  && ifu_bus.rready;
        hs_lsu_ar = lsu_bus.arvalid && lsu_bus.arready;
        hs_lsu_r  = lsu_bus.rvalid  && lsu_bus.rready;
        hs_lsu_aw = lsu_bus.awvalid && lsu_bus.awready;
        hs_lsu_w  = lsu_bus.wvalid  && lsu_bus.wready;
        hs_lsu_b  = lsu_bus.bvalid  && lsu_bus.bready;
        hs_m_ar   = m_bus.arvalid && m_bus.arready;
        hs_m_r    = m_bus.rvalid  && m_bus.rready;
        hs_m_aw   = m_bus.awvalid && m_bus.awready;
        hs_m_w    = m_bus.wvalid  && m_bus.wready;
        hs_m_b    = m_bus.bvalid  && m_bus.bready;

        if (hs_m_ar) begin
            cap_ar_addr = m_bus.araddr;
            cap_ar_id   = m_bus.arid;
            $display("m_ar   addr=%h id=%0d", m_bus.araddr, m_bus.arid);
            if (m_ar_q.size() == 0) fail_evt("m_ar");
            else begin
                ea = m_ar_q.pop_front();
                chk("m_ar", 64'({m_bus.araddr, m_bus.arid, m_bus.arlen, m_bus.arsize, m_bus.arburst}),
                    64'({ea.addr, ea.id, 8'h00, 3'b010, 2'b01}));
            end
        end
        if (hs_m_aw) begin
            cap_aw_id = m_bus.awid;
            $display("m_aw   addr=%h id=%0d", m_bus.awaddr, m_bus.awid);
            if (m_aw_q.size() == 0) fail_evt("m_aw");
            else begin
                ea = m_aw_q.pop_front();
                chk("m_aw", 64'({m_bus.awaddr, m_bus.awid, m_bus.awlen, m_bus.awsize, m_bus.awburst}),
                    64'({ea.addr, ea.id, 8'h00, 3'b010, 2'b01}));
            end
        end
        if (hs_m_w) begin
            $display("m_w    data=%h strb=%b last=%b", m_bus.wdata, m_bus.wstrb, m_bus.wlast);
            if (m_w_q.size() == 0) fail_evt("m_w");
            else begin
                ew = m_w_q.pop_front();
                chk("m_w", 64'({m_bus.wdata, m_bus.wstrb, m_bus.wlast}), 64'({ew.data, ew.strb, 1'b1}));
            end
        end
        if (hs_ifu_r) begin
            $display("ifu_r  data=%h resp=%0d", ifu_bus.rdata, ifu_bus.rresp);
            if (ifu_r_q.size() == 0) fail_evt("ifu_r");
            else begin
                er = ifu_r_q.pop_front();
                chk("ifu_r", 64'({ifu_bus.rdata, ifu_bus.rresp}), 64'({er.data, er.resp}));
            end
        end
        if (hs_lsu_r) begin
            $display("lsu_r  data=%h resp=%0d", lsu_bus.rdata, lsu_bus.rresp);
            if (lsu_r_q.size() == 0) fail_evt("lsu_r");
            else begin
                er = lsu_r_q.pop_front();
                chk("lsu_r", 64'({lsu_bus.rdata, lsu_bus.rresp}), 64'({er.data, er.resp}));
            end
        end
        if (hs_lsu_b) begin
            $display("lsu_b  resp=%0d", lsu_bus.bresp);
            if (lsu_b_q.size() == 0) fail_evt("lsu_b");
            else chk("lsu_b", 64'(lsu_bus.bresp), 64'(lsu_b_q.pop_front()));
        end
        // an upstream ready may only appear while that master owns the port
        if (ifu_bus.arready === 1'b1)
            chk("ifu_arready_route", 64'({m_bus.arvalid, m_bus.arid, m_bus.araddr}),
                64'({1'b1, ID_IFU, ifu_bus.araddr}));
        if (lsu_bus.arready === 1'b1)
            chk("lsu_arready_route", 64'({m_bus.arvalid, m_bus.arid, m_bus.araddr}),
                64'({1'b1, ID_LSU, lsu_bus.araddr}));
    end

    // ---------------- memory slave model ----------------
    initial begin : slave_rd
        m_bus.arready = 1'b1;
        m_bus.rvalid  = 1'b0;
        m_bus.rdata   = '0;
        m_bus.rresp   = '0;
        m_bus.rid     = '0;
        m_bus.rlast   = 1'b0;
        forever begin
            tick();
            if (hs_m_ar) begin
                logic [31:0] a;
                logic [3:0]  id;
                a  = cap_ar_addr;
                id = cap_ar_id;
                repeat (slave_lat) tick();
                m_bus.rvalid = 1'b1;
                m_bus.rdata  = {a[15:0], 16'h0413};
                m_bus.rresp  = slave_rresp;
                m_bus.rid    = id;
                m_bus.rlast  = 1'b1;
                do tick(); while (!hs_m_r && !slave_abort);
                m_bus.rvalid = 1'b0;
            end
        end
    end

    initial begin : slave_wr
        m_bus.awready = 1'b1;
        m_bus.wready  = 1'b1;
        m_bus.bvalid  = 1'b0;
        m_bus.bresp   = '0;
        m_bus.bid     = '0;
        forever begin
            logic aw_seen, w_seen;
            aw_seen = 1'b0;
            w_seen  = 1'b0;
            while (!(aw_seen && w_seen)) begin
                tick();
                if (hs_m_aw) aw_seen = 1'b1;
                if (hs_m_w)  w_seen  = 1'b1;
            end
            repeat (slave_lat) tick();
            m_bus.bvalid = 1'b1;
            m_bus.bresp  = slave_bresp;
            m_bus.bid    = cap_aw_id;
            do tick(); while (!hs_m_b && !slave_abort);
            m_bus.bvalid = 1'b0;
        end
    end

    // ---------------- upstream masters ----------------
    task automatic ifu_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                            output int cyc);
        int n;
        ifu_r_q.push_back('{data: d, resp: resp});
        ifu_bus.araddr  = a;
        ifu_bus.arvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!hs_ifu_ar && n < TMO);
        ifu_bus.arvalid = 1'b0;
        if (!hs_ifu_ar) fail_evt("ifu_ar_timeout");
        do begin tick(); n++; end while (!hs_ifu_r && n < 2 * TMO);
        if (!hs_ifu_r) fail_evt("ifu_r_timeout");
        cyc = n;
    endtask

    task automatic lsu_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                            output int cyc);
        int n;
        lsu_r_q.push_back('{data: d, resp: resp});
        lsu_bus.araddr  = a;
        lsu_bus.arvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!hs_lsu_ar && n < TMO);
        lsu_bus.arvalid = 1'b0;
        if (!hs_lsu_ar) fail_evt("lsu_ar_timeout");
        do begin tick(); n++; end while (!hs_lsu_r && n < 2 * TMO);
        if (!hs_lsu_r) fail_evt("lsu_r_timeout");
        cyc = n;
    endtask

    task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int wdly, input logic [1:0] exp_b);
        int n;
        m_aw_q.push_back('{addr: a, id: ID_LSU});
        m_w_q.push_back('{data: d, strb: s});
        lsu_b_q.push_back(exp_b);
        lsu_bus.awaddr  = a;
        lsu_bus.wdata   = d;
        lsu_bus.wstrb   = s;
        lsu_bus.awvalid = 1'b1;
        fork
            begin
                int n1 = 0;
                do begin tick(); n1++; end while (!hs_lsu_aw && n1 < TMO);
                lsu_bus.awvalid = 1'b0;
                if (!hs_lsu_aw) fail_evt("lsu_aw_timeout");
            end
            begin
                int n2 = 0;
                repeat (wdly) tick();
                lsu_bus.wvalid = 1'b1;
                do begin tick(); n2++; end while (!hs_lsu_w && n2 < TMO);
                lsu_bus.wvalid = 1'b0;
                if (!hs_lsu_w) fail_evt("lsu_w_timeout");
            end
        join
        n = 0;
        while (!hs_lsu_b && n < TMO) begin tick(); n++; end
        if (!hs_lsu_b) fail_evt("lsu_b_timeout");
    endtask

    task automatic idle_zero(input string nm);
        @(negedge clk);
        chk(nm, 64'({m_bus.arvalid, m_bus.awvalid, m_bus.wvalid, m_bus.rready, m_bus.bready,
                     ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready, lsu_bus.rvalid,
                     lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid}), 64'(0));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int c1, c2, n;
        ifu_bus.araddr = '0; ifu_bus.arid = '0; ifu_bus.arlen = '0; ifu_bus.arsize = '0;
        ifu_bus.arburst = '0; ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b1;
        ifu_bus.awaddr = '0; ifu_bus.awid = '0; ifu_bus.awlen = '0; ifu_bus.awsize = '0;
        ifu_bus.awburst = '0; ifu_bus.awvalid = 1'b0; ifu_bus.wdata = '0; ifu_bus.wstrb = '0;
        ifu_bus.wlast = 1'b0; ifu_bus.wvalid = 1'b0; ifu_bus.bready = 1'b0;
        lsu_bus.araddr = '0; lsu_bus.arid = '0; lsu_bus.arlen = '0; lsu_bus.arsize = '0;
        lsu_bus.arburst = '0; lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b1;
        lsu_bus.awaddr = '0; lsu_bus.awid = '0; lsu_bus.awlen = '0; lsu_bus.awsize = '0;
        lsu_bus.awburst = '0; lsu_bus.awvalid = 1'b0; lsu_bus.wdata = '0; lsu_bus.wstrb = '0;
        lsu_bus.wlast = 1'b0; lsu_bus.wvalid = 1'b0; lsu_bus.bready = 1'b1;

        repeat (3) tick();
        idle_zero("reset_outputs");
        rst = 1'b0;
        tick();

        // IFU alone: grant cycle + ar cycle + 1 slave cycle + r cycle
        m_ar_q.push_back('{addr: 32'h8000_0000, id: ID_IFU});
        ifu_read(32'h8000_0000, 32'h0000_0413, RESP_OKAY, c1);
        chk("ifu_alone_latency", 64'(c1), 64'(4));
        idle_zero("ifu_alone_back_to_idle");

        // IFU and LSU in the same IDLE cycle: LSU first (both builds, last=IFU)
        tick();
        m_ar_q.push_back('{addr: 32'h8000_1000, id: ID_LSU});
        m_ar_q.push_back('{addr: 32'h8000_0004, id: ID_IFU});
        fork
            lsu_read(32'h8000_1000, 32'h1000_0413, RESP_OKAY, c1);
            ifu_read(32'h8000_0004, 32'h0004_0413, RESP_OKAY, c2);
        join
        chk("lsu_first_latency", 64'(c1), 64'(4));
        chk("ifu_behind_lsu_latency", 64'(c2), 64'(8));

        // write with w two cycles after aw
        tick();
        lsu_write(32'h8000_2000, 32'hDEAD_BEEF, 4'b0011, 2, RESP_OKAY);

        // write with aw and w together, slave error response
        tick();
        slave_bresp = RESP_SLVERR;
        lsu_write(32'h8000_2004, 32'h1234_5678, 4'b1111, 0, RESP_SLVERR);
        slave_bresp = RESP_OKAY;
        idle_zero("slverr_write_back_to_idle");

        // read error passes through unchanged
        tick();
        slave_rresp = RESP_SLVERR;
        m_ar_q.push_back('{addr: 32'h8000_0008, id: ID_IFU});
        ifu_read(32'h8000_0008, 32'h0008_0413, RESP_SLVERR, c1);
        slave_rresp = RESP_OKAY;

        // reset in LSU_RD before the slave answers; nothing may be forwarded
        tick();
        slave_lat = 6;
        m_ar_q.push_back('{addr: 32'h8000_3000, id: ID_LSU});
        lsu_bus.araddr  = 32'h8000_3000;
        lsu_bus.arvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!hs_lsu_ar && n < TMO);
        lsu_bus.arvalid = 1'b0;
        if (!hs_lsu_ar) fail_evt("rst_test_ar_timeout");
        tick();
        rst = 1'b1;
        tick();
        idle_zero("rst_mid_lsu_rd");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            if (m_bus.rvalid)
                chk("stale_rvalid_blocked", 64'({lsu_bus.rvalid, ifu_bus.rvalid, m_bus.rready}), 64'(0));
        end
        slave_abort = 1'b1;
        repeat (2) tick();
        slave_abort = 1'b0;
        slave_lat = 1;
        tick();

        // both masters requesting back to back for four transactions
`ifdef ARB_RR_EN
        m_ar_q.push_back('{addr: 32'h8000_4000, id: ID_LSU});
        m_ar_q.push_back('{addr: 32'h8000_0010, id: ID_IFU});
        m_ar_q.push_back('{addr: 32'h8000_4004, id: ID_LSU});
        m_ar_q.push_back('{addr: 32'h8000_0014, id: ID_IFU});
`else
        m_ar_q.push_back('{addr: 32'h8000_4000, id: ID_LSU});
        m_ar_q.push_back('{addr: 32'h8000_4004, id: ID_LSU});
        m_ar_q.push_back('{addr: 32'h8000_0010, id: ID_IFU});
        m_ar_q.push_back('{addr: 32'h8000_0014, id: ID_IFU});
`endif
        fork
            begin
                int a1, a2;
                lsu_read(32'h8000_4000, 32'h4000_0413, RESP_OKAY, a1);
                lsu_read(32'h8000_4004, 32'h4004_0413, RESP_OKAY, a2);
            end
            begin
                int b1, b2;
                ifu_read(32'h8000_0010, 32'h0010_0413, RESP_OKAY, b1);
                ifu_read(32'h8000_0014, 32'h0014_0413, RESP_OKAY, b2);
            end
        join
        idle_zero("contention_back_to_idle");

        repeat (2) tick();
        chk("scoreboard_drained", 64'(m_ar_q.size() + m_aw_q.size() + m_w_q.size()
                                      + ifu_r_q.size() + lsu_r_q.size() + lsu_b_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
